fp_mac_sequencer: RTL and testbench



---
 rtl/fp_mac_sequencer_pkg.sv | 26 ++
 rtl/fp_mac_sequencer_if.sv | 53 +++++
 rtl/fp_mac_sequencer_delay_cnt.sv | 34 +++
 rtl/fp_mac_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fp_mac_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fp_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mac_pkg
//  Brief    : Shared types and constants for the fp_mac sequencer slice.
//  Revision : 1.0  initial release
// ============================================================================
package fp_mac_pkg;

  // Sequencer FSM states, explicit 3-bit encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_OP = 3'd1,
    MUL     = 3'd2,
    ADD     = 3'd3,
    DONE    = 3'd4
  } state_t;

  // IEEE-754 single-precision +0.0, muxed in as the first accumulator operand
  localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

  // Default pipeline latencies of the fp_mac datapath
  localparam int MUL_LAT_DEF = 3;
  localparam int ADD_LAT_DEF = 2;

endpackage
`default_nettype wire

// File: rtl/fp_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mac_sequencer_if
//  Brief    : Job / operand handshake and datapath control bundle.
//             master = job requester / operand source, slave = sequencer.
//             Macro FP_MAC_SEQ_PERF_EN adds the cycle_count signal.
//  Revision : 1.0  initial release
// ============================================================================
interface fp_mac_sequencer_if #(
  parameter int LEN_W = 8
) ();

  logic             start;
  logic [LEN_W-1:0] length;
  logic             op_valid;
  logic             op_ready;
  logic             mul_issue;
  logic             add_issue;
  logic             acc_zero_sel;
  logic             acc_load;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] products_done;
`ifdef FP_MAC_SEQ_PERF_EN
  logic [15:0]      cycle_count;

  modport master (
    output start, length, op_valid,
    input  op_ready, mul_issue, add_issue, acc_zero_sel, acc_load,
           busy, done, products_done, cycle_count
  );

  modport slave (
    input  start, length, op_valid,
    output op_ready, mul_issue, add_issue, acc_zero_sel, acc_load,
           busy, done, products_done, cycle_count
  );
`else
  modport master (
    output start, length, op_valid,
    input  op_ready, mul_issue, add_issue, acc_zero_sel, acc_load,
           busy, done, products_done
  );

  modport slave (
    input  start, length, op_valid,
    output op_ready, mul_issue, add_issue, acc_zero_sel, acc_load,
           busy, done, products_done
  );
`endif

endinterface
`default_nettype wire

// File: rtl/fp_mac_sequencer_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mac_delay_cnt
//  Brief    : Loadable down-counter with zero flag; times the multiplier and
//             adder pipeline waits. Stops at zero until reloaded.
//  Revision : 1.0  initial release
// ============================================================================
module fp_mac_delay_cnt #(
  parameter int WIDTH = 2
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             i_load,
  input  wire logic [WIDTH-1:0] i_load_val,
  output logic                  o_zero
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down and park at zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/fp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mac_sequencer
//  Brief    : Control FSM sequencing one multiply-accumulate job through the
//             fp_mac datapath (multiplier -> adder -> accumulator). Adds are
//             serialised so each one sees the previous sum.
//             Optional macro FP_MAC_SEQ_PERF_EN adds a saturating busy-cycle
//             counter (bus.cycle_count).
//  Revision : 1.0  initial release
// ============================================================================
module fp_mac_sequencer
  import fp_mac_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int LEN_W   = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  fp_mac_sequencer_if.slave  bus
);

  // Counter only ever holds LAT-1, so clog2(max LAT) bits suffice
  localparam int c_LAT_MAX = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int c_CNT_W   = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_ADD_LOAD = c_CNT_W'(ADD_LAT - 1);

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_length;
  logic [LEN_W-1:0]   r_products_done;
  logic [LEN_W-1:0]   w_pd_inc;
  logic               w_accept;
  logic               w_step;
  logic               w_cnt_load;
  logic [c_CNT_W-1:0] w_cnt_val;
  logic               w_cnt_zero;
  logic               w_op_ready;
  logic               w_mul_issue;
  logic               w_add_issue;
  logic               w_acc_zero_sel;
  logic               w_acc_load;
  logic               w_busy;
  logic               w_done;

  // Wraps at LEN_W bits, so length = all-ones completes on the exact match
  assign w_pd_inc = r_products_done + 1'b1;

  fp_mac_delay_cnt #(
    .WIDTH (c_CNT_W)
  ) u_delay_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_zero     (w_cnt_zero)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and state-decoded strobes; only mul_issue sees an input directly
  always_comb begin
    w_next         = r_state;
    w_accept       = 1'b0;
    w_step         = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_val      = c_MUL_LOAD;
    w_op_ready     = 1'b0;
    w_mul_issue    = 1'b0;
    w_add_issue    = 1'b0;
    w_acc_zero_sel = 1'b0;
    w_acc_load     = 1'b0;
    w_busy         = 1'b1;
    w_done         = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = (bus.length == '0) ? DONE : WAIT_OP;
        end
      end
      WAIT_OP: begin
        w_op_ready  = 1'b1;
        w_mul_issue = bus.op_valid;
        if (bus.op_valid) begin
          w_cnt_load = 1'b1;
          w_cnt_val  = c_MUL_LOAD;
          w_next     = MUL;
        end
      end
      MUL: begin
        if (w_cnt_zero) begin
          w_add_issue    = 1'b1;
          w_acc_zero_sel = (r_products_done == '0);
          w_cnt_load     = 1'b1;
          w_cnt_val      = c_ADD_LOAD;
          w_next         = ADD;
        end
      end
      ADD: begin
        if (w_cnt_zero) begin
          w_acc_load = 1'b1;
          w_step     = 1'b1;
          w_next     = (w_pd_inc == r_length) ? DONE : WAIT_OP;
        end
      end
      DONE: begin
        w_done = 1'b1;
        // Empty job: load +0.0 into the result register alongside done
        if (r_length == '0) begin
          w_acc_load     = 1'b1;
          w_acc_zero_sel = 1'b1;
        end
        w_next = IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  // Job length capture and progress counter; progress holds after done
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_length        <= '0;
      r_products_done <= '0;
    end else if (w_accept) begin
      r_length        <= bus.length;
      r_products_done <= '0;
    end else if (w_step) begin
      r_products_done <= w_pd_inc;
    end
  end

  assign bus.op_ready      = w_op_ready;
  assign bus.mul_issue     = w_mul_issue;
  assign bus.add_issue     = w_add_issue;
  assign bus.acc_zero_sel  = w_acc_zero_sel;
  assign bus.acc_load      = w_acc_load;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.products_done = r_products_done;

`ifdef FP_MAC_SEQ_PERF_EN
  logic [15:0] r_cycle_count;

  // Busy-cycle counter: cleared on accepted start, saturating, holds when idle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (w_accept) begin
      r_cycle_count <= '0;
    end else if ((r_state != IDLE) && (r_cycle_count != 16'hFFFF)) begin
      r_cycle_count <= r_cycle_count + 16'd1;
    end
  end

  assign bus.cycle_count = r_cycle_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_mac_sequencer
//  Brief    : Directed self-checking bench for fp_mac_sequencer with
//             MUL_LAT=3, ADD_LAT=2. Cycle 0 of each job is the start cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_mac_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fp_mac_sequencer_if #(.LEN_W(8)) bus ();

  fp_mac_sequencer #(
    .MUL_LAT (3),
    .ADD_LAT (2),
    .LEN_W   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  int q_mul[$];
  int q_add[$];
  int q_zsel[$];
  int q_load[$];
  int q_done[$];
  int q_busy[$];
  int pd_trace [0:63];
  int rdy_trace[0:63];
  int nz_trace [0:63];
  int pd_last;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int any_out();
    return int'(|{bus.op_ready, bus.mul_issue, bus.add_issue, bus.acc_zero_sel,
                  bus.acc_load, bus.busy, bus.done, bus.products_done});
  endfunction

  // Start a job at cycle 0, record output events per cycle. start_again pulses
  // start (length 5) at that cycle; op_valid is low in [lo_from, lo_to];
  // reset is pulsed for one cycle at rst_cyc.
  task automatic run_job(input int len, input int ncyc, input int start_again,
                         input int lo_from, input int lo_to, input int rst_cyc);
    logic [7:0] len8;
    len8 = 8'(len);
    q_mul.delete(); q_add.delete(); q_zsel.delete();
    q_load.delete(); q_done.delete(); q_busy.delete();
    for (int k = 0; k < 64; k++) begin
      pd_trace[k] = -1; rdy_trace[k] = -1; nz_trace[k] = -1;
    end
    for (int c = 0; c < ncyc; c++) begin
      bus.start    = (c == 0) || (c == start_again);
      bus.length   = (c == 0) ? len8 : 8'd5;
      bus.op_valid = !((c >= lo_from) && (c <= lo_to));
      reset        = (c == rst_cyc);
      @(negedge clock);
      if (bus.mul_issue)    q_mul.push_back(c);
      if (bus.add_issue)    q_add.push_back(c);
      if (bus.acc_zero_sel) q_zsel.push_back(c);
      if (bus.acc_load)     q_load.push_back(c);
      if (bus.done)         q_done.push_back(c);
      if (bus.busy)         q_busy.push_back(c);
      if (c < 64) begin
        pd_trace[c]  = int'(bus.products_done);
        rdy_trace[c] = int'(bus.op_ready);
        nz_trace[c]  = any_out();
      end
      pd_last = int'(bus.products_done);
      @(posedge clock);
      #1;
    end
    bus.start    = 1'b0;
    bus.op_valid = 1'b0;
    reset        = 1'b0;
  endtask

  initial begin
    int rdy_sum;
    bus.start    = 1'b0;
    bus.length   = 8'd0;
    bus.op_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", any_out(), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Single product, op_valid from cycle 1, start re-pulsed at cycle 3
    run_job(1, 12, 3, 0, 0, -1);
    check("t1_mul_cnt",   q_mul.size(), 1);
    check("t1_mul0",      at(q_mul, 0), 1);
    check("t1_add0",      at(q_add, 0), 4);
    check("t1_zsel_cnt",  q_zsel.size(), 1);
    check("t1_zsel0",     at(q_zsel, 0), 4);
    check("t1_load0",     at(q_load, 0), 6);
    check("t1_done_cnt",  q_done.size(), 1);
    check("t1_done0",     at(q_done, 0), 7);
    check("t1_busy_cnt",  q_busy.size(), 7);
    check("t1_busy_first", at(q_busy, 0), 1);
    check("t1_busy_last", at(q_busy, 6), 7);
    check("t1_pd_final",  pd_last, 1);
`ifdef FP_MAC_SEQ_PERF_EN
    check("t1_cycle_count", int'(bus.cycle_count), 7);
`endif

    // Three products, op_valid always high
    run_job(3, 25, -1, -1, -1, -1);
    check("t2_mul_cnt",  q_mul.size(), 3);
    check("t2_mul0",     at(q_mul, 0), 1);
    check("t2_mul1",     at(q_mul, 1), 7);
    check("t2_mul2",     at(q_mul, 2), 13);
    check("t2_zsel_cnt", q_zsel.size(), 1);
    check("t2_zsel0",    at(q_zsel, 0), 4);
    check("t2_pd6",      pd_trace[6], 0);
    check("t2_pd7",      pd_trace[7], 1);
    check("t2_pd13",     pd_trace[13], 2);
    check("t2_pd19",     pd_trace[19], 3);
    check("t2_done_cnt", q_done.size(), 1);
    check("t2_done0",    at(q_done, 0), 19);

    // Back-pressure: second pair withheld during cycles 7..10
    run_job(2, 22, -1, 7, 10, -1);
    rdy_sum = 0;
    for (int c = 7; c <= 10; c++) rdy_sum += rdy_trace[c];
    check("t3_ready_wait", rdy_sum, 4);
    check("t3_mul1",      at(q_mul, 1), 11);
    check("t3_add_cnt",   q_add.size(), 2);
    check("t3_add1",      at(q_add, 1), 14);
    check("t3_load_cnt",  q_load.size(), 2);
    check("t3_load1",     at(q_load, 1), 16);
    check("t3_done0",     at(q_done, 0), 17);

    // Zero-length job
    run_job(0, 5, -1, -1, -1, -1);
    check("t4_done0",    at(q_done, 0), 1);
    check("t4_done_cnt", q_done.size(), 1);
    check("t4_load0",    at(q_load, 0), 1);
    check("t4_zsel0",    at(q_zsel, 0), 1);
    check("t4_mul_cnt",  q_mul.size(), 0);
    check("t4_add_cnt",  q_add.size(), 0);
    check("t4_busy_cnt", q_busy.size(), 1);

    // Reset during ADD of product 2 of 4 (cycle 11)
    run_job(4, 20, -1, -1, -1, 11);
    check("t5_pre_reset_pd", pd_trace[10], 1);
    check("t5_outs_at_reset", nz_trace[11], 0);
    check("t5_outs_after",    nz_trace[12], 0);
    check("t5_done_cnt",      q_done.size(), 0);
    check("t5_mul_cnt",       q_mul.size(), 2);

    // Normal job after the aborted one
    run_job(1, 10, -1, -1, -1, -1);
    check("t6_zsel0",   at(q_zsel, 0), 4);
    check("t6_done0",   at(q_done, 0), 7);
    check("t6_pd_final", pd_last, 1);

    // Maximum length, no wrap of the progress counter
    run_job(255, 1540, -1, -1, -1, -1);
    check("t7_mul_cnt",  q_mul.size(), 255);
    check("t7_done_cnt", q_done.size(), 1);
    check("t7_done0",    at(q_done, 0), 1531);
    check("t7_pd_final", pd_last, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
